m_uart_rx_core: RTL and testbench

M_UART_RX_CORE -- requirements
Module: m_uart_rx_core

---
 rtl/uart_pkg.sv | 24 ++
 rtl/m_uart_bit_sampler.sv | 51 +++++
 rtl/m_uart_rx_core.sv | 189 ++++++++++++++++++
 tb/tb_m_uart_rx_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, parity modes and the
// spacing of the three majority-vote samples around the bit centre.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Clocks between the centre sample and each flanking vote sample.
  localparam int unsigned SAMPLE_OFS = 1;

  function automatic logic f_majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/m_uart_bit_sampler.sv
// Bit timer (0..CLKS_PER_BIT-1, held at 0 while idle) plus 2-of-3 vote around the bit centre.
// The voted bit is presented with o_sample once the last of the three samples is on the line.
module m_uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_rx,
  output logic o_sample,
  output logic o_bit,
  output logic o_bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(CLKS_PER_BIT / 2 - SAMPLE_OFS);
  localparam logic [CW-1:0] C_S1   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_S2   = CW'(CLKS_PER_BIT / 2 + SAMPLE_OFS);

  logic [CW-1:0] r_cnt;
  logic          r_s0;
  logic          r_s1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == C_S0) r_s0 <= i_rx;
      if (r_cnt == C_S1) r_s1 <= i_rx;
    end
  end

  assign o_sample  = i_run && (r_cnt == C_S2);
  assign o_bit     = f_majority3(r_s0, r_s1, i_rx);
  assign o_bit_end = i_run && (r_cnt == C_LAST);

endmodule

// File: rtl/m_uart_rx_core.sv
// UART receiver: 2-FF synchronised line, majority-voted bits, one-cycle o_rx_en per frame.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module m_uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rx,
  input  logic [1:0]           i_parity_mode,
  output logic                 o_rx_en,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam logic [3:0] C_DB      = 4'(DATA_BITS);
  localparam logic [3:0] C_SB_LAST = 4'(STOP_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [1:0]           r_warm;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 w_done;
  logic                 w_run;
  logic                 w_fall;
  logic                 w_sample;
  logic                 w_bit;
  logic                 w_bit_end;
  logic                 w_par_on;
  logic                 w_par_err;
  logic                 r_rx_en;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_break;

  // r_prev only records a high once r_sync2 carries a real line sample, so
  // after reset the line must genuinely be seen high before a start is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_warm  <= 2'b00;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      r_prev  <= r_sync2 & r_warm[1];
    end
  end

  assign w_fall = r_prev & ~r_sync2;
  assign w_run  = (r_state != ST_IDLE);

  m_uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (w_run),
    .i_rx     (r_sync2),
    .o_sample (w_sample),
    .o_bit    (w_bit),
    .o_bit_end(w_bit_end)
  );

`ifdef UART_RX_PARITY_EN
  logic [1:0] r_par_mode;
  logic       r_par_bit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_par_mode <= PAR_NONE;
      r_par_bit  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_par_mode <= i_parity_mode;
      if (r_state == ST_PARITY && w_sample) r_par_bit <= w_bit;
    end
  end

  assign w_par_on  = (r_par_mode == PAR_ODD) || (r_par_mode == PAR_EVEN);
  assign w_par_err = w_par_on && ((^{r_shift, r_par_bit}) != (r_par_mode == PAR_ODD));
`else
  logic w_unused_parity_mode;
  assign w_unused_parity_mode = ^i_parity_mode;
  assign w_par_on  = 1'b0;
  assign w_par_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ferr_nxt    = r_ferr;
    w_done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_bit_cnt_nxt = '0;
        w_ferr_nxt    = 1'b0;
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_sample && w_bit) w_state_nxt = ST_IDLE;
        else if (w_bit_end)    w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_sample) begin
          w_shift_nxt   = {w_bit, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
        if (w_bit_end && r_bit_cnt == C_DB) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_par_on ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the centre of the last stop bit so a following start edge is never missed.
        if (w_sample) begin
          if (!w_bit) w_ferr_nxt = 1'b1;
          if (r_bit_cnt == C_SB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_en      <= 1'b0;
      r_rx_data    <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break      <= 1'b0;
    end else begin
      r_rx_en <= w_done;
      if (w_done) begin
        r_rx_data    <= r_shift;
        r_frame_err  <= w_ferr_nxt;
        r_parity_err <= w_par_err;
        r_break      <= w_ferr_nxt && (r_shift == '0);
      end
    end
  end

  assign o_rx_en      = r_rx_en;
  assign o_rx_data    = r_rx_data;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_break      = r_break;
  assign o_busy       = w_run;

endmodule

// File: tb/tb_m_uart_rx_core.sv
// Directed bench for m_uart_rx_core at 16 clocks/bit, 8 data bits, 1 stop bit.
// Parity rows are added when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_m_uart_rx_core;

  localparam int CPB = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic [1:0] i_parity_mode = 2'd0;
  logic       o_rx_en;
  logic [7:0] o_rx_data;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_break;
  logic       o_busy;

  m_uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_uart_rx    (i_uart_rx),
    .i_parity_mode(i_parity_mode),
    .o_rx_en      (o_rx_en),
    .o_rx_data    (o_rx_data),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_break      (o_break),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       send_par;
    logic       par_bit;
    logic       stop_val;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
    logic       exp_brk;
  } vec_t;

  vec_t tv[10];
  int   n_vec;
  int   n_cmp  = 0;
  int   n_fail = 0;

  int         rx_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] last_data;
  logic       last_ferr;
  logic       last_perr;
  logic       last_brk;

  always @(posedge i_clk) begin
    #1;
    if (o_rx_en) begin
      rx_cnt++;
      rx_q.push_back(o_rx_data);
      last_data = o_rx_data;
      last_ferr = o_frame_err;
      last_perr = o_parity_err;
      last_brk  = o_break;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int blen(input int k, input bit jit);
    if (!jit) return CPB;
    return (k % 2 == 0) ? CPB + 1 : CPB - 1;
  endfunction

  task automatic send_bit(input logic v, input int len);
    i_uart_rx = v;
    repeat (len) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic sp, input logic pb,
                            input logic sv, input bit jit);
    int k;
    k = 0;
    send_bit(1'b0, blen(k, jit)); k++;
    for (int b = 0; b < 8; b++) begin
      send_bit(d[b], blen(k, jit)); k++;
    end
    if (sp) begin
      send_bit(pb, blen(k, jit)); k++;
    end
    send_bit(sv, blen(k, jit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [7:0] d0;
    logic [7:0] d1;

    tv[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h80, 2'd0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
    tv[4] = '{8'h01, 2'd3, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
`ifdef UART_RX_PARITY_EN
    tv[5] = '{8'h03, 2'd2, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    tv[6] = '{8'h03, 2'd2, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tv[7] = '{8'h03, 2'd1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    tv[8] = '{8'h07, 2'd1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    n_vec = 9;
`else
    tv[5] = '{8'h03, 2'd2, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    n_vec = 6;
`endif

    // Reset state
    repeat (4) @(negedge i_clk);
    check("rst_rx_en", o_rx_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_rx_data, 0);
    check("rst_errs", {o_frame_err, o_parity_err, o_break}, 0);
    i_rst_n = 1'b1;
    repeat (3 * CPB) @(negedge i_clk);

    // Table-driven single frames
    for (int v = 0; v < n_vec; v++) begin
      i_parity_mode = tv[v].mode;
      last_data = ~tv[v].exp_data;
      last_ferr = ~tv[v].exp_ferr;
      last_perr = ~tv[v].exp_perr;
      last_brk  = ~tv[v].exp_brk;
      repeat (2) @(negedge i_clk);
      c0 = rx_cnt;
      send_frame(tv[v].data, tv[v].send_par, tv[v].par_bit, tv[v].stop_val, 1'b0);
      check($sformatf("v%0d_busy_at_stop_end", v), o_busy, 0);
      i_uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge i_clk);
      check($sformatf("v%0d_pulses", v), rx_cnt - c0, 1);
      check($sformatf("v%0d_data", v), last_data, tv[v].exp_data);
      check($sformatf("v%0d_frame_err", v), last_ferr, tv[v].exp_ferr);
      check($sformatf("v%0d_parity_err", v), last_perr, tv[v].exp_perr);
      check($sformatf("v%0d_break", v), last_brk, tv[v].exp_brk);
      check($sformatf("v%0d_data_hold", v), o_rx_data, tv[v].exp_data);
    end
    i_parity_mode = 2'd0;

    // 4-cycle low glitch on an idle line
    c0 = rx_cnt;
    i_uart_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (2) @(negedge i_clk);
    check("glitch_busy_seen", o_busy, 1);
    repeat (16) @(negedge i_clk);
    check("glitch_busy_cleared", o_busy, 0);
    repeat (2 * CPB) @(negedge i_clk);
    check("glitch_no_pulse", rx_cnt - c0, 0);

    // Back-to-back 0x55, 0xAA: clean, then with +/-1 cycle bit-length jitter
    for (int j = 0; j < 2; j++) begin
      rx_q.delete();
      c0 = rx_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, j[0]);
      send_frame(8'hAA, 1'b0, 1'b0, 1'b1, j[0]);
      i_uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge i_clk);
      d0 = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      d1 = (rx_q.size() > 1) ? rx_q[1] : 8'h00;
      check($sformatf("b2b%0d_pulses", j), rx_cnt - c0, 2);
      check($sformatf("b2b%0d_first", j), d0, 8'h55);
      check($sformatf("b2b%0d_second", j), d1, 8'hAA);
    end

    // One-cycle reset in the middle of data bit 3 of an all-zero frame
    c0 = rx_cnt;
    send_bit(1'b0, CPB);
    for (int b = 0; b < 3; b++) send_bit(1'b0, CPB);
    send_bit(1'b0, CPB / 2);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check("midrst_data_cleared", o_rx_data, 0);
    check("midrst_busy", o_busy, 0);
    send_bit(1'b0, CPB / 2 - 1 + 4 * CPB);
    send_bit(1'b1, 3 * CPB);
    check("midrst_no_pulse", rx_cnt - c0, 0);
    check("midrst_idle", o_busy, 0);
    c0 = rx_cnt;
    last_data = 8'h00;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    i_uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge i_clk);
    check("post_rst_pulses", rx_cnt - c0, 1);
    check("post_rst_data", last_data, 8'h3C);
    check("post_rst_errs", {last_ferr, last_perr, last_brk}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
